// File: rtl/cpu_pkg.sv
// Shared widths, opcode map and HALT encoding for the 8-bit pipelined CPU.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 8;

  // Instruction layout: [7:6] opcode, [5:3] rx, [2:0] ry
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_OUT  = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  localparam logic [2:0] COND_GT = 3'b000;
  localparam logic [2:0] COND_LT = 3'b001;
  localparam logic [2:0] COND_EQ = 3'b010;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 8'h00;

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter for the fetch stage performance monitors.
module fetch_perf_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, RUN/HALTED FSM and IF/ID register with valid/ready to decode.
// Optional FETCH_PERF_EN adds saturating fetch_count / stall_count monitors.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_count
`endif
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic               capture;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    out_pc_d = out_pc_q;
    capture  = 1'b0;

    if (redirect_valid) begin
      // Flush IF/ID; the word on imem_instr this cycle is dropped, even a HALT.
      pc_d    = redirect_target;
      valid_d = 1'b0;
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (run) begin
            capture = !valid_q || out_ready;
            if (capture) begin
              instr_d  = imem_instr;
              out_pc_d = pc_q;
              valid_d  = 1'b1;
              if (imem_instr == HALT_INSTR) begin
                state_d = StHalted;
              end else begin
                pc_d = pc_q + ADDR_W'(1);
              end
            end
          end else if (out_ready) begin
            valid_d = 1'b0;
          end
        end
        StHalted: begin
          if (out_ready) begin
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      out_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      out_pc_q <= out_pc_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = out_pc_q;
  assign halted    = (state_q == StHalted);

`ifdef FETCH_PERF_EN
  logic stall;
  assign stall = valid_q && !out_ready;

  fetch_perf_cnt #(
    .WIDTH (16)
  ) u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (capture),
    .count (fetch_count)
  );

  fetch_perf_cnt #(
    .WIDTH (16)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (stall_count)
  );
`endif

endmodule
